// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the DMA transfer engine.
// Imported by dma_master and dma_buf.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP,
    DONE
  } dma_state_e;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int          MAX_BURST      = 16;
  localparam logic [12:0] BOUNDARY_4K    = 13'h1000;

endpackage

// File: rtl/dma_buf.sv
// Burst staging buffer: one synchronous write port, one combinational read port.
// Holds one read burst until it is replayed on the write channel.
module dma_buf
  import dma_pkg::*;
#(
  parameter int DEPTH  = MAX_BURST,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dma_master.sv
// AXI DMA transfer engine: INCR read bursts into a local buffer, then matching
// INCR write bursts, split so that no burst crosses a 4 KB boundary.
module dma_master #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter int              ID_W      = 4,
  parameter int              LEN_W     = 4,
  parameter int              MAX_BURST = 16,
  parameter logic [ID_W-1:0] MST_ID    = ID_W'(2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DMAEN,
  input  logic [31:0]       DMASRC,
  input  logic [31:0]       DMADST,
  input  logic [31:0]       DMALEN,
  output logic              DMA_interrupt,
  output logic              DMA_err,
  output logic [ID_W-1:0]   M_ARID,
  output logic [ADDR_W-1:0] M_ARAddr,
  output logic [LEN_W-1:0]  M_ARLen,
  output logic [2:0]        M_ARSize,
  output logic [1:0]        M_ARBurst,
  output logic              M_ARValid,
  input  logic              M_ARReady,
  input  logic [ID_W-1:0]   M_RID,
  input  logic [DATA_W-1:0] M_RData,
  input  logic [1:0]        M_RResp,
  input  logic              M_RLast,
  input  logic              M_RValid,
  output logic              M_RReady,
  output logic [ID_W-1:0]   M_AWID,
  output logic [ADDR_W-1:0] M_AWAddr,
  output logic [LEN_W-1:0]  M_AWLen,
  output logic [2:0]        M_AWSize,
  output logic [1:0]        M_AWBurst,
  output logic              M_AWValid,
  input  logic              M_AWReady,
  output logic [DATA_W-1:0] M_WData,
  output logic [3:0]        M_WStrb,
  output logic              M_WLast,
  output logic              M_WValid,
  input  logic              M_WReady,
  input  logic [ID_W-1:0]   M_BID,
  input  logic [1:0]        M_BResp,
  input  logic              M_BValid,
  output logic              M_BReady
);

  import dma_pkg::*;

  dma_state_e        state, next_state;
  logic [ADDR_W-1:0] src, dst, src_adv, dst_adv;
  logic [31:0]       rem, rem_adv;
  logic [LEN_W:0]    beats, beats_nxt;
  logic [LEN_W-1:0]  idx;
  logic              w_last;
  logic              buf_wr;
  logic              unused_ok;

  // Largest burst that fits the remaining length, the buffer and both 4 KB pages.
  function automatic logic [LEN_W:0] calc_beats(input logic [ADDR_W-1:0] s,
                                                input logic [ADDR_W-1:0] d,
                                                input logic [31:0]       r);
    logic [12:0] s_room, d_room;
    logic [31:0] b;
    s_room = (BOUNDARY_4K - {1'b0, s[11:0]}) >> 2;
    d_room = (BOUNDARY_4K - {1'b0, d[11:0]}) >> 2;
    b = 32'(MAX_BURST);
    if (r < b) b = r;
    if ({19'd0, s_room} < b) b = {19'd0, s_room};
    if ({19'd0, d_room} < b) b = {19'd0, d_room};
    return (LEN_W+1)'(b);
  endfunction

  assign src_adv = src + ADDR_W'({beats, 2'b00});
  assign dst_adv = dst + ADDR_W'({beats, 2'b00});
  assign rem_adv = rem - 32'(beats);
  assign w_last  = ({1'b0, idx} == beats - (LEN_W+1)'(1));
  assign buf_wr  = (state == RDATA) && M_RValid;

  assign M_ARID    = MST_ID;
  assign M_AWID    = MST_ID;
  assign M_ARSize  = AXI_SIZE_4B;
  assign M_AWSize  = AXI_SIZE_4B;
  assign M_ARBurst = AXI_BURST_INCR;
  assign M_AWBurst = AXI_BURST_INCR;
  assign M_WStrb   = 4'hF;
  assign M_ARAddr  = src;
  assign M_AWAddr  = dst;
  assign M_ARLen   = LEN_W'(beats - (LEN_W+1)'(1));
  assign M_AWLen   = LEN_W'(beats - (LEN_W+1)'(1));
  assign M_WLast   = w_last;
  assign unused_ok = ^{M_RID, M_BID};

  dma_buf #(
    .DEPTH (MAX_BURST),
    .DATA_W(DATA_W),
    .IDX_W (LEN_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_wr),
    .wr_idx (idx),
    .wr_data(M_RData),
    .rd_idx (idx),
    .rd_data(M_WData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    beats_nxt  = beats;
    M_ARValid  = 1'b0;
    M_RReady   = 1'b0;
    M_AWValid  = 1'b0;
    M_WValid   = 1'b0;
    M_BReady   = 1'b0;
    case (state)
      IDLE: begin
        if (DMAEN) begin
          if (DMALEN == 32'd0) begin
            next_state = DONE;
          end else begin
            next_state = RADDR;
            beats_nxt  = calc_beats(ADDR_W'(DMASRC), ADDR_W'(DMADST), DMALEN);
          end
        end
      end
      RADDR: begin
        M_ARValid = 1'b1;
        if (M_ARReady) next_state = RDATA;
      end
      RDATA: begin
        M_RReady = 1'b1;
        if (M_RValid && M_RLast) next_state = WADDR;
      end
      WADDR: begin
        M_AWValid = 1'b1;
        if (M_AWReady) next_state = WDATA;
      end
      WDATA: begin
        M_WValid = 1'b1;
        if (M_WReady && w_last) next_state = WRESP;
      end
      WRESP: begin
        M_BReady = 1'b1;
        if (M_BValid) begin
          if (rem_adv == 32'd0 || !DMAEN) begin
            next_state = DONE;
          end else begin
            next_state = RADDR;
            beats_nxt  = calc_beats(src_adv, dst_adv, rem_adv);
          end
        end
      end
      DONE: begin
        if (!DMAEN) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Interrupt is only raised when the transfer ends with the enable still high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src           <= '0;
      dst           <= '0;
      rem           <= '0;
      beats         <= '0;
      idx           <= '0;
      DMA_err       <= 1'b0;
      DMA_interrupt <= 1'b0;
    end else begin
      beats         <= beats_nxt;
      DMA_interrupt <= (next_state == DONE) && DMAEN;
      case (state)
        IDLE: begin
          if (DMAEN) begin
            src     <= ADDR_W'(DMASRC);
            dst     <= ADDR_W'(DMADST);
            rem     <= DMALEN;
            idx     <= '0;
            DMA_err <= 1'b0;
          end
        end
        RDATA: begin
          if (M_RValid) begin
            idx <= M_RLast ? '0 : idx + LEN_W'(1);
            if (M_RResp != AXI_RESP_OKAY ||
                (M_RLast && ({1'b0, idx} + (LEN_W+1)'(1)) != beats)) begin
              DMA_err <= 1'b1;
            end
          end
        end
        WDATA: begin
          if (M_WReady) idx <= w_last ? '0 : idx + LEN_W'(1);
        end
        WRESP: begin
          if (M_BValid) begin
            src <= src_adv;
            dst <= dst_adv;
            rem <= rem_adv;
            if (M_BResp != AXI_RESP_OKAY) DMA_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_master.sv
// Directed bench for dma_master with a small AXI slave model (memory, bursts,
// optional random backpressure) and hand-computed expected bursts/data.
module tb_dma_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic        DMA_interrupt, DMA_err;
  logic [3:0]  M_ARID, M_AWID;
  logic [31:0] M_ARAddr, M_AWAddr, M_WData;
  logic [3:0]  M_ARLen, M_AWLen, M_WStrb;
  logic [2:0]  M_ARSize, M_AWSize;
  logic [1:0]  M_ARBurst, M_AWBurst;
  logic        M_ARValid, M_RReady, M_AWValid, M_WLast, M_WValid, M_BReady;
  logic        ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid;
  logic [31:0] r_data;
  logic [1:0]  r_resp, b_resp;

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;
  bit err_first_b = 0;

  logic [31:0] ar_log[$], aw_log[$], rd_addr_q[$], wr_addr_q[$];
  int          arlen_log[$], awlen_log[$], rd_len_q[$], wr_len_q[$];
  int          w_beats, b_count, pending_b, r_beat, w_beat;
  int          stab_viol, lat_viol, wlast_err, proto_err, irq_seen;
  logic [31:0] dst_mem [0:16383];

  always #5 clk = ~clk;

  dma_master dut (
    .clk(clk), .rst(rst),
    .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
    .DMA_interrupt(DMA_interrupt), .DMA_err(DMA_err),
    .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
    .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(ar_ready),
    .M_RID(4'd2), .M_RData(r_data), .M_RResp(r_resp), .M_RLast(r_last),
    .M_RValid(r_valid), .M_RReady(M_RReady),
    .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
    .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(aw_ready),
    .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
    .M_WReady(w_ready),
    .M_BID(4'd2), .M_BResp(b_resp), .M_BValid(b_valid), .M_BReady(M_BReady)
  );

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return 32'hA5C3_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic bit roll();
    return $urandom_range(99) < ready_pct;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Handshakes are decided at the falling edge (values are stable until the
  // next rising edge) and their effects applied just after that rising edge.
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rlast_prev;
    bit ar_hold, aw_hold, w_hold, cap_wlast;
    logic [31:0] ar_hold_addr, aw_hold_addr, w_hold_data;
    logic [31:0] cap_ar_addr, cap_aw_addr, cap_wdata, waddr;
    int cap_ar_len, cap_aw_len;
    ar_ready = 0; r_valid = 0; r_last = 0; r_data = '0; r_resp = 2'b00;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    rlast_prev = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
    forever begin
      @(negedge clk);
      ar_hs = M_ARValid && ar_ready;
      r_hs  = r_valid && M_RReady;
      aw_hs = M_AWValid && aw_ready;
      w_hs  = M_WValid && w_ready;
      b_hs  = b_valid && M_BReady;
      cap_ar_addr = M_ARAddr; cap_ar_len = int'(M_ARLen);
      cap_aw_addr = M_AWAddr; cap_aw_len = int'(M_AWLen);
      cap_wdata = M_WData;    cap_wlast = M_WLast;
      if (ar_hold && (!M_ARValid || M_ARAddr != ar_hold_addr)) stab_viol++;
      if (aw_hold && (!M_AWValid || M_AWAddr != aw_hold_addr)) stab_viol++;
      if (w_hold && (!M_WValid || M_WData != w_hold_data)) stab_viol++;
      ar_hold = M_ARValid && !ar_ready; ar_hold_addr = M_ARAddr;
      aw_hold = M_AWValid && !aw_ready; aw_hold_addr = M_AWAddr;
      w_hold  = M_WValid && !w_ready;   w_hold_data  = M_WData;
      if (rlast_prev && !M_AWValid) lat_viol++;
      rlast_prev = r_hs && r_last;
      if (DMA_interrupt) irq_seen++;
      @(posedge clk);
      #1;
      if (!rst) begin
        rd_addr_q.delete(); rd_len_q.delete(); wr_addr_q.delete(); wr_len_q.delete();
        r_beat = 0; w_beat = 0; pending_b = 0;
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        rlast_prev = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
        continue;
      end
      if (ar_hs) begin
        rd_addr_q.push_back(cap_ar_addr); rd_len_q.push_back(cap_ar_len);
        ar_log.push_back(cap_ar_addr);    arlen_log.push_back(cap_ar_len);
      end
      if (r_hs) begin
        if (r_last) begin
          void'(rd_addr_q.pop_front()); void'(rd_len_q.pop_front()); r_beat = 0;
        end else begin
          r_beat++;
        end
      end
      if (aw_hs) begin
        wr_addr_q.push_back(cap_aw_addr); wr_len_q.push_back(cap_aw_len);
        aw_log.push_back(cap_aw_addr);    awlen_log.push_back(cap_aw_len);
      end
      if (w_hs) begin
        w_beats++;
        if (wr_addr_q.size() == 0) begin
          proto_err++;
        end else begin
          waddr = wr_addr_q[0] + 32'(w_beat * 4);
          dst_mem[waddr[15:2]] = cap_wdata;
          if (cap_wlast != (w_beat == wr_len_q[0])) wlast_err++;
          if (w_beat == wr_len_q[0]) begin
            void'(wr_addr_q.pop_front()); void'(wr_len_q.pop_front());
            w_beat = 0; pending_b++;
          end else begin
            w_beat++;
          end
        end
      end
      if (b_hs) begin
        pending_b--; b_count++;
      end
      ar_ready = roll();
      aw_ready = roll();
      w_ready  = roll();
      if (!(r_valid && !r_hs)) r_valid = (rd_addr_q.size() > 0) && roll();
      if (rd_addr_q.size() > 0) begin
        r_data = src_word(rd_addr_q[0] + 32'(r_beat * 4));
        r_last = (r_beat == rd_len_q[0]);
      end
      if (!(b_valid && !b_hs)) b_valid = (pending_b > 0) && roll();
      b_resp = (err_first_b && b_count == 0) ? 2'b10 : 2'b00;
    end
  end

  task automatic clearLogs();
    ar_log.delete(); arlen_log.delete(); aw_log.delete(); awlen_log.delete();
    w_beats = 0; b_count = 0; irq_seen = 0;
    for (int i = 0; i < 16384; i++) dst_mem[i] = 32'hDEAD_DEAD;
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                               input logic [31:0] len);
    @(negedge clk);
    clearLogs();
    DMASRC = src; DMADST = dst; DMALEN = len; DMAEN = 1'b1;
  endtask

  task automatic waitIrq(input string tag, input int budget);
    for (int i = 0; i < budget && !DMA_interrupt; i++) @(negedge clk);
    checkOutput(tag, 32'(DMA_interrupt), 32'd1);
  endtask

  task automatic stopEngine();
    DMAEN = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkData(input string tag, input logic [31:0] src,
                           input logic [31:0] dst, input int len);
    int bad = 0;
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      a = dst + 32'(i * 4);
      if (dst_mem[a[15:2]] !== src_word(src + 32'(i * 4))) bad++;
    end
    checkOutput(tag, 32'(bad), 32'd0);
  endtask

  task automatic checkBursts(input string tag, input logic [31:0] ar_base,
                             input logic [31:0] aw_base, input int lens[3], input int n);
    logic [31:0] ar_a, aw_a;
    checkOutput({tag, "_ar_count"}, 32'(ar_log.size()), 32'(n));
    checkOutput({tag, "_aw_count"}, 32'(aw_log.size()), 32'(n));
    ar_a = ar_base; aw_a = aw_base;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_ar%0d_addr", tag, i), ar_log[i], ar_a);
      checkOutput($sformatf("%s_ar%0d_len", tag, i), 32'(arlen_log[i]), 32'(lens[i] - 1));
      checkOutput($sformatf("%s_aw%0d_addr", tag, i), aw_log[i], aw_a);
      checkOutput($sformatf("%s_aw%0d_len", tag, i), 32'(awlen_log[i]), 32'(lens[i] - 1));
      ar_a += 32'(lens[i] * 4);
      aw_a += 32'(lens[i] * 4);
    end
  endtask

  initial begin
    rst = 1'b0; DMAEN = 1'b0; DMASRC = '0; DMADST = '0; DMALEN = '0;
    stab_viol = 0; lat_viol = 0; wlast_err = 0; proto_err = 0;
    clearLogs();
    repeat (3) @(negedge clk);
    checkOutput("rst_valids", 32'({M_ARValid, M_RReady, M_AWValid, M_WValid, M_BReady}), 32'd0);
    checkOutput("rst_irq_err", 32'({DMA_interrupt, DMA_err}), 32'd0);
    checkOutput("const_ar", 32'({M_ARID, M_ARSize, M_ARBurst}), 32'({4'd2, 3'b010, 2'b01}));
    checkOutput("const_aw", 32'({M_AWID, M_AWSize, M_AWBurst, M_WStrb}),
                32'({4'd2, 3'b010, 2'b01, 4'hF}));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] T1 single 4-word burst");
    applyStimulus(32'h1000, 32'h2000, 32'd4);
    @(negedge clk);
    checkOutput("T1_arvalid_latency", 32'(M_ARValid), 32'd1);
    checkOutput("T1_araddr", M_ARAddr, 32'h1000);
    checkOutput("T1_arlen", 32'(M_ARLen), 32'd3);
    waitIrq("T1_irq", 200);
    checkBursts("T1", 32'h1000, 32'h2000, '{4, 0, 0}, 1);
    checkOutput("T1_w_beats", 32'(w_beats), 32'd4);
    checkData("T1_data", 32'h1000, 32'h2000, 4);
    DMAEN = 1'b0;
    #1;
    checkOutput("T1_irq_hold", 32'(DMA_interrupt), 32'd1);
    @(negedge clk);
    checkOutput("T1_irq_clear", 32'(DMA_interrupt), 32'd0);
    @(negedge clk);

    $display("[TB] T2 40 words in three bursts");
    applyStimulus(32'h1000, 32'h2000, 32'd40);
    waitIrq("T2_irq", 1000);
    checkBursts("T2", 32'h1000, 32'h2000, '{16, 16, 8}, 3);
    checkData("T2_data", 32'h1000, 32'h2000, 40);
    stopEngine();

    $display("[TB] T3 4 KB boundary split");
    applyStimulus(32'h1FF8, 32'h3000, 32'd4);
    waitIrq("T3_irq", 500);
    checkBursts("T3", 32'h1FF8, 32'h3000, '{2, 2, 0}, 2);
    checkData("T3_data", 32'h1FF8, 32'h3000, 4);
    stopEngine();

    $display("[TB] T4 random backpressure");
    ready_pct = 50;
    applyStimulus(32'h1100, 32'h2100, 32'd20);
    waitIrq("T4_irq", 3000);
    checkBursts("T4", 32'h1100, 32'h2100, '{16, 4, 0}, 2);
    checkData("T4_data", 32'h1100, 32'h2100, 20);
    checkOutput("T4_stability", 32'(stab_viol), 32'd0);
    stopEngine();
    ready_pct = 100;

    $display("[TB] T5 zero-length transfer");
    applyStimulus(32'h1000, 32'h2000, 32'd0);
    @(negedge clk);
    checkOutput("T5_irq_next_cycle", 32'(DMA_interrupt), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("T5_no_axi", 32'(ar_log.size() + aw_log.size() + w_beats), 32'd0);
    stopEngine();

    $display("[TB] T6 write error response");
    err_first_b = 1;
    applyStimulus(32'h1000, 32'h2800, 32'd20);
    waitIrq("T6_irq", 1000);
    checkOutput("T6_err", 32'(DMA_err), 32'd1);
    checkOutput("T6_b_count", 32'(b_count), 32'd2);
    checkData("T6_data", 32'h1000, 32'h2800, 20);
    err_first_b = 0;
    stopEngine();

    $display("[TB] T7 enable dropped during first read burst");
    applyStimulus(32'h1000, 32'h3000, 32'd40);
    @(negedge clk);
    checkOutput("T7_err_cleared", 32'(DMA_err), 32'd0);
    for (int i = 0; i < 50 && !M_RReady; i++) @(negedge clk);
    checkOutput("T7_in_rdata", 32'(M_RReady), 32'd1);
    DMAEN = 1'b0;
    irq_seen = 0;
    repeat (200) @(negedge clk);
    checkOutput("T7_ar_count", 32'(ar_log.size()), 32'd1);
    checkOutput("T7_w_beats", 32'(w_beats), 32'd16);
    checkOutput("T7_b_count", 32'(b_count), 32'd1);
    checkOutput("T7_irq_never", 32'(irq_seen), 32'd0);
    checkOutput("T7_idle", 32'({M_ARValid, M_AWValid, M_WValid}), 32'd0);
    checkData("T7_data", 32'h1000, 32'h3000, 16);

    checkOutput("aw_latency", 32'(lat_viol), 32'd0);
    checkOutput("wlast", 32'(wlast_err), 32'd0);
    checkOutput("w_without_aw", 32'(proto_err), 32'd0);
    checkOutput("stability_all", 32'(stab_viol), 32'd0);

    $display("[TB] T8 async reset during write data");
    applyStimulus(32'h1000, 32'h2000, 32'd16);
    for (int i = 0; i < 200 && !M_WValid; i++) @(negedge clk);
    checkOutput("T8_in_wdata", 32'(M_WValid), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("T8_valids_cleared",
                32'({M_ARValid, M_RReady, M_AWValid, M_WValid, M_BReady}), 32'd0);
    checkOutput("T8_irq_err", 32'({DMA_interrupt, DMA_err}), 32'd0);
    DMAEN = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("T8_idle_after", 32'({M_ARValid, M_AWValid, DMA_interrupt}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
